// File: rtl/dispatch_credit_unit.sv
// dispatch_credit_unit: credit-checked dispatch stage between the decoder and the reservation stations
// Ports: clk/reset_n (async active-low); flush restores all credits and empties the output register.
//   in_*  : decoded instruction handshake (in_valid/in_ready) with station select, RS/ROB needs, payload.
//   out_* : registered instruction toward the RS (out_valid/out_ready) with the allocated ROB tag.
//   alu_release/br_release/rob_commit : one credit returned per cycle-pulse.
// Optional: DISPATCH_PERF_EN adds stall_cnt (input stalled cycles) and drop_cnt (discarded no-ROB instructions).
module dispatch_credit_unit #(
  parameter int DATA_W = 32,
  parameter int ALU_DEPTH = 4,
  parameter int BR_DEPTH = 2,
  parameter int ROB_DEPTH = 16,
  localparam int ROB_AW = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rs_station,
  input  logic              in_station_req,
  input  logic              in_rob_write,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_rs_station,
  output logic              out_station_req,
  output logic [ROB_AW-1:0] out_rob_tag,
  output logic [DATA_W-1:0] out_data,
`ifdef DISPATCH_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [15:0]       drop_cnt,
`endif
  input  logic              alu_release,
  input  logic              br_release,
  input  logic              rob_commit
);
  localparam int AC_W = $clog2(ALU_DEPTH + 1);
  localparam int BC_W = $clog2(BR_DEPTH + 1);
  localparam int RC_W = $clog2(ROB_DEPTH + 1);
  localparam logic [AC_W-1:0] ALU_FULL = AC_W'(ALU_DEPTH);
  localparam logic [BC_W-1:0] BR_FULL = BC_W'(BR_DEPTH);
  localparam logic [RC_W-1:0] ROB_FULL = RC_W'(ROB_DEPTH);
  logic [AC_W-1:0] alu_cnt;
  logic [BC_W-1:0] br_cnt;
  logic [RC_W-1:0] rob_cnt;
  logic [ROB_AW-1:0] tail;
  logic need_alu, need_br, ok, acc, load, alu_take, br_take;
  assign need_alu = in_station_req & (in_rs_station == 2'b00);
  assign need_br = in_station_req & (in_rs_station == 2'b01);
  assign ok = (!need_alu | alu_cnt != '0) & (!need_br | br_cnt != '0) & (!in_rob_write | rob_cnt != '0);
  assign in_ready = !flush & (!out_valid | out_ready) & ok;
  assign acc = in_valid & in_ready;
  // Only ROB-writing instructions are forwarded; the rest are swallowed without touching any credit.
  assign load = acc & in_rob_write;
  assign alu_take = load & need_alu;
  assign br_take = load & need_br;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_rs_station <= 2'b11;
      out_station_req <= 1'b0;
      out_rob_tag <= '0;
      out_data <= '0;
      alu_cnt <= ALU_FULL;
      br_cnt <= BR_FULL;
      rob_cnt <= ROB_FULL;
      tail <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      alu_cnt <= ALU_FULL;
      br_cnt <= BR_FULL;
      rob_cnt <= ROB_FULL;
      tail <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_rs_station <= in_rs_station;
        out_station_req <= in_station_req;
        out_rob_tag <= tail;
        out_data <= in_data;
        tail <= tail + 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      // Take and return in the same cycle cancel; a return at full count is dropped.
      alu_cnt <= alu_take & !alu_release ? alu_cnt - 1'b1 :
                 !alu_take & alu_release & alu_cnt != ALU_FULL ? alu_cnt + 1'b1 : alu_cnt;
      br_cnt <= br_take & !br_release ? br_cnt - 1'b1 :
                !br_take & br_release & br_cnt != BR_FULL ? br_cnt + 1'b1 : br_cnt;
      rob_cnt <= load & !rob_commit ? rob_cnt - 1'b1 :
                 !load & rob_commit & rob_cnt != ROB_FULL ? rob_cnt + 1'b1 : rob_cnt;
    end
`ifdef DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stall_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (in_valid & !in_ready & !flush) stall_cnt <= stall_cnt + 1'b1;
      if (acc & !in_rob_write) drop_cnt <= drop_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dispatch_credit_unit.sv
// tb_dispatch_credit_unit: directed table plus hand sequences for dispatch_credit_unit
module tb_dispatch_credit_unit;
  typedef struct {
    logic iv;
    logic [1:0] rs;
    logic sr, rw;
    logic [31:0] d;
    logic ordy, arel, brel, cmt, fl;
    logic e_rdy, e_ov;
    int e_tag;
    logic [31:0] e_data;
    int e_alu, e_br, e_rob, e_tail;
  } vec_t;
  logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, in_station_req = 0, in_rob_write = 0;
  logic out_ready = 0, alu_release = 0, br_release = 0, rob_commit = 0;
  logic [1:0] in_rs_station = 2'b11;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, out_station_req;
  logic [1:0] out_rs_station;
  logic [3:0] out_rob_tag;
  logic [31:0] out_data;
`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] drop_cnt;
`endif
  int vectors = 0, miscompares = 0;
  vec_t tv[17];
  always #5 clk = ~clk;
  dispatch_credit_unit dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_station(in_rs_station), .in_station_req(in_station_req), .in_rob_write(in_rob_write),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_rs_station(out_rs_station),
    .out_station_req(out_station_req), .out_rob_tag(out_rob_tag), .out_data(out_data),
`ifdef DISPATCH_PERF_EN
    .stall_cnt(stall_cnt), .drop_cnt(drop_cnt),
`endif
    .alu_release(alu_release), .br_release(br_release), .rob_commit(rob_commit));
  // kind: 0 ALU, 1 branch, 2 ROB-only (JAL), 3 discarded (no ROB), 4 idle
  function automatic vec_t mk(int k, logic [31:0] d, bit ordy, bit arel, bit brel, bit cmt, bit fl,
                              bit er, bit eov, int etag, logic [31:0] edata, int ea, int eb, int erb, int et);
    vec_t v;
    v.iv = k != 4;
    v.rs = k == 0 ? 2'b00 : k == 1 ? 2'b01 : 2'b11;
    v.sr = k < 2;
    v.rw = k < 3;
    v.d = d;
    v.ordy = ordy; v.arel = arel; v.brel = brel; v.cmt = cmt; v.fl = fl;
    v.e_rdy = er; v.e_ov = eov; v.e_tag = etag; v.e_data = edata;
    v.e_alu = ea; v.e_br = eb; v.e_rob = erb; v.e_tail = et;
    return v;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic idle_inputs();
    in_valid = 0; in_rs_station = 2'b11; in_station_req = 0; in_rob_write = 0; in_data = 0;
    out_ready = 0; alu_release = 0; br_release = 0; rob_commit = 0; flush = 0;
  endtask
  task automatic step(string nm, vec_t v);
    @(negedge clk);
    in_valid = v.iv; in_rs_station = v.rs; in_station_req = v.sr; in_rob_write = v.rw; in_data = v.d;
    out_ready = v.ordy; alu_release = v.arel; br_release = v.brel; rob_commit = v.cmt; flush = v.fl;
    vectors++;
    #1 chk({nm, " in_ready"}, 32'(in_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1 chk({nm, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
    if (v.e_ov) begin
      chk({nm, " out_rob_tag"}, 32'(out_rob_tag), 32'(v.e_tag));
      chk({nm, " out_data"}, out_data, v.e_data);
    end
    chk({nm, " alu_cnt"}, 32'(dut.alu_cnt), 32'(v.e_alu));
    chk({nm, " br_cnt"}, 32'(dut.br_cnt), 32'(v.e_br));
    chk({nm, " rob_cnt"}, 32'(dut.rob_cnt), 32'(v.e_rob));
    chk({nm, " tail"}, 32'(dut.tail), 32'(v.e_tail));
  endtask
  task automatic do_reset(string nm);
    @(negedge clk);
    idle_inputs();
    reset_n = 0;
    vectors++;
    #1 chk({nm, " out_valid"}, 32'(out_valid), 0);
    chk({nm, " out_rs_station"}, 32'(out_rs_station), 3);
    chk({nm, " out_station_req"}, 32'(out_station_req), 0);
    chk({nm, " out_rob_tag"}, 32'(out_rob_tag), 0);
    chk({nm, " out_data"}, out_data, 0);
    chk({nm, " credits"}, {8'(dut.alu_cnt), 8'(dut.br_cnt), 8'(dut.rob_cnt), 8'(dut.tail)}, 32'h0402_1000);
`ifdef DISPATCH_PERF_EN
    chk({nm, " perf"}, stall_cnt | 32'(drop_cnt), 0);
`endif
    @(negedge clk);
    reset_n = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = mk(0, 32'hA0, 1, 0, 0, 0, 0, 1, 1, 0, 32'hA0, 3, 2, 15, 1);
    tv[1]  = mk(0, 32'hA1, 1, 0, 0, 0, 0, 1, 1, 1, 32'hA1, 2, 2, 14, 2);
    tv[2]  = mk(0, 32'hA2, 1, 0, 0, 0, 0, 1, 1, 2, 32'hA2, 1, 2, 13, 3);
    tv[3]  = mk(0, 32'hA3, 1, 0, 0, 0, 0, 1, 1, 3, 32'hA3, 0, 2, 12, 4);
    tv[4]  = mk(0, 32'hA4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 12, 4);
    tv[5]  = mk(0, 32'hA4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 12, 4);
    tv[6]  = mk(0, 32'hA4, 1, 0, 0, 0, 0, 1, 1, 4, 32'hA4, 0, 2, 11, 5);
    tv[7]  = mk(1, 32'hB0, 0, 0, 0, 0, 0, 0, 1, 4, 32'hA4, 0, 2, 11, 5);
    tv[8]  = mk(1, 32'hB0, 0, 0, 0, 0, 0, 0, 1, 4, 32'hA4, 0, 2, 11, 5);
    tv[9]  = mk(1, 32'hB0, 1, 0, 0, 0, 0, 1, 1, 5, 32'hB0, 0, 1, 10, 6);
    tv[10] = mk(1, 32'hB1, 1, 0, 1, 0, 0, 1, 1, 6, 32'hB1, 0, 1, 9, 7);
    tv[11] = mk(4, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2, 9, 7);
    tv[12] = mk(4, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2, 9, 7);
    tv[13] = mk(1, 32'hB3, 1, 0, 0, 0, 0, 1, 1, 7, 32'hB3, 0, 1, 8, 8);
    tv[14] = mk(1, 32'hB4, 1, 0, 0, 0, 0, 1, 1, 8, 32'hB4, 0, 0, 7, 9);
    tv[15] = mk(1, 32'hB5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 9);
    tv[16] = mk(4, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 8, 9);
    do_reset("reset0");
    for (int i = 0; i < 17; i++) step($sformatf("v%0d", i), tv[i]);
    do_reset("reset1");
    step("commit_full", mk(4, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 4, 2, 16, 0));
    step("drop", mk(3, 32'hDEAD, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4, 2, 16, 0));
`ifdef DISPATCH_PERF_EN
    chk("drop drop_cnt", 32'(drop_cnt), 1);
    chk("drop stall_cnt", stall_cnt, 0);
`endif
    for (int i = 0; i < 3; i++)
      step($sformatf("fl_alu%0d", i), mk(0, 32'hC0 + i, 1, 0, 0, 0, 0, 1, 1, i, 32'hC0 + i, 3 - i, 2, 15 - i, i + 1));
    for (int i = 0; i < 4; i++)
      step($sformatf("fl_jal%0d", i), mk(2, 32'hD0 + i, 1, 0, 0, 0, 0, 1, 1, 3 + i, 32'hD0 + i, 1, 2, 12 - i, 4 + i));
    step("flush", mk(0, 32'hE0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 2, 16, 0));
    step("post_flush", mk(0, 32'hE1, 1, 0, 0, 0, 0, 1, 1, 0, 32'hE1, 3, 2, 15, 1));
    do_reset("reset_mid");
    for (int i = 0; i < 16; i++)
      step($sformatf("rob%0d", i), mk(2, 32'hF00 + i, 1, 0, 0, 0, 0, 1, 1, i, 32'hF00 + i, 4, 2, 15 - i, (i + 1) % 16));
    step("rob_full", mk(2, 32'hF10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 2, 0, 0));
    step("rob_commit", mk(2, 32'hF10, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4, 2, 1, 0));
    step("rob_wrap", mk(2, 32'hF10, 1, 0, 0, 0, 0, 1, 1, 0, 32'hF10, 4, 2, 0, 1));
`ifdef DISPATCH_PERF_EN
    chk("end stall_cnt", stall_cnt, 2);
    chk("end drop_cnt", 32'(drop_cnt), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
